// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register of the MIPS datapath.
// It registers the execute-stage result for the memory-access stage and
// supports stall, flush and halt. Store data is replicated across byte
// lanes. Misaligned accesses are flagged and suppressed, and a saturating
// counter tracks how many memory operations were captured.
module ex_mem_stage #(
  parameter int TAM_DATA     = 32,
  parameter int TAM_MASK     = 2,
  parameter int NUM_REG_BITS = 5,
  parameter int CNT_BITS     = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_stall,
  input  logic                    i_flush,
  input  logic                    i_valid,
  input  logic                    i_halt,
  input  logic                    i_wr_mem,
  input  logic                    i_is_unsigned,
  input  logic                    i_mem_to_reg,
  input  logic                    i_reg_write,
  input  logic [TAM_MASK-1:0]     i_data_mask,
  input  logic [TAM_DATA-1:0]     i_alu_result,
  input  logic [TAM_DATA-1:0]     i_store_data,
  input  logic [NUM_REG_BITS-1:0] i_rd,
  output logic                    o_valid,
  output logic                    o_wr_mem,
  output logic                    o_is_unsigned,
  output logic                    o_mem_to_reg,
  output logic                    o_reg_write,
  output logic                    o_halt,
  output logic [TAM_MASK-1:0]     o_data_mask,
  output logic [TAM_DATA-1:0]     o_direc_mem,
  output logic [TAM_DATA-1:0]     o_data,
  output logic [NUM_REG_BITS-1:0] o_rd,
  output logic                    o_misaligned,
  output logic [TAM_DATA-1:0]     o_fault_addr,
  output logic [CNT_BITS-1:0]     o_mem_op_count
);

  // The stage runs normally until a HALT is captured. It then stays frozen until reset.
  typedef enum logic {
    ST_RUN,
    ST_FROZEN
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  state_t              r_state;
  state_t              w_nextState;
  logic                w_capture;
  logic                w_bubble;
  logic                w_memOp;
  logic                w_isWord;
  logic                w_isHalf;
  logic                w_misaligned;
  logic [TAM_DATA-1:0] w_laneData;

  // Decode the access size, misalignment, lane replication and the capture/bubble decision.
  always_comb begin
    w_memOp      = i_wr_mem | i_mem_to_reg;
    w_isWord     = i_data_mask[TAM_MASK-1];
    w_isHalf     = (i_data_mask == TAM_MASK'(1));
    w_misaligned = w_memOp & ((w_isHalf & i_alu_result[0]) |
                              (w_isWord & (i_alu_result[1:0] != 2'b00)));
    if (w_isWord) begin
      w_laneData = i_store_data;
    end else if (w_isHalf) begin
      w_laneData = {(TAM_DATA/16){i_store_data[15:0]}};
    end else begin
      w_laneData = {(TAM_DATA/8){i_store_data[7:0]}};
    end
    w_capture = ~i_flush & ~i_stall & i_valid;
    w_bubble  = i_flush | (~i_stall & ~i_valid);
  end

  // Next-state logic: a captured HALT freezes the stage. A flushed HALT does not.
  always_comb begin
    w_nextState = r_state;
    if ((r_state == ST_RUN) && w_capture && i_halt) begin
      w_nextState = ST_FROZEN;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Pipeline register. Priority: frozen, then flush/bubble, then stall, then capture.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid        <= 1'b0;
      o_wr_mem       <= 1'b0;
      o_is_unsigned  <= 1'b0;
      o_mem_to_reg   <= 1'b0;
      o_reg_write    <= 1'b0;
      o_halt         <= 1'b0;
      o_data_mask    <= '0;
      o_direc_mem    <= '0;
      o_data         <= '0;
      o_rd           <= '0;
      o_misaligned   <= 1'b0;
      o_fault_addr   <= '0;
      o_mem_op_count <= '0;
    end else if (r_state == ST_FROZEN) begin
      o_halt <= 1'b1;
    end else if (w_bubble) begin
      o_valid      <= 1'b0;
      o_wr_mem     <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_reg_write  <= 1'b0;
      o_halt       <= 1'b0;
    end else if (w_capture) begin
      o_valid       <= 1'b1;
      o_wr_mem      <= i_wr_mem & ~w_misaligned;
      o_is_unsigned <= i_is_unsigned;
      o_mem_to_reg  <= i_mem_to_reg & ~w_misaligned;
      o_reg_write   <= i_reg_write & ~w_misaligned;
      o_halt        <= i_halt;
      o_data_mask   <= i_data_mask;
      o_direc_mem   <= i_alu_result;
      o_data        <= w_laneData;
      o_rd          <= i_rd;
      if (w_misaligned) begin
        o_misaligned <= 1'b1;
        if (!o_misaligned) begin
          o_fault_addr <= i_alu_result;
        end
      end
      if (w_memOp && (o_mem_op_count != CNT_MAX)) begin
        o_mem_op_count <= o_mem_op_count + 1'b1;
      end
    end
  end

endmodule
